fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Control sequencer for the time-multiplexed 64-tap FIR datapath: delay line, coefficient ROM and single MAC.
- Replaces the free-running counter with a valid/ready sample handshake, so one MAC unit serves one sample per frame without sample slips.
- Drives the delay-line shift strobe, the shared tap address (delay-line read plus coefficient ROM), and the MAC clear/enable/last controls.
- Holds out_valid until the downstream consumer accepts.

Parameters:
- TAPS, 64, number of filter taps (MAC iterations per output sample); must be ≥ 2.
- COUNT_BIT_NUM, 6, width of tap_addr; must satisfy 2^COUNT_BIT_NUM ≥ TAPS.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream has a sample on filter_data_in.
- in_ready  output  1  sequencer can accept a sample this cycle.
- out_ready  input  1  downstream accepts the filter result.
- out_valid  output  1  MAC accumulator holds a complete result.
- shift_en  output  1  one-cycle strobe: shift the accepted sample into the delay line.
- tap_addr  output  COUNT_BIT_NUM  tap index for the delay-line read mux and the coefficient ROM.
- mac_clr  output  1  clear the accumulator to zero.
- mac_en  output  1  accumulate data_delay × coeff this cycle.
- mac_last  output  1  high on the final accumulate cycle (tap_addr = TAPS-1).
- busy  output  1  high in every state except IDLE.
- frame_cnt  output  16  number of completed output handshakes; wraps at 0xFFFF → 0.

Behaviour:
- All outputs are registered (driven from state/counter flops). No combinational path from inputs to outputs, except that in_ready and out_valid are pure state decodes.
- Reset (asynchronous assert, synchronous release):
  - state = IDLE, tap_addr = 0, frame_cnt = 0.
  - in_ready = 1; all other outputs = 0.
  - Reset mid-frame aborts the frame immediately; the partial result is discarded and no out_valid is produced.
- FSM states: IDLE, LOAD, MAC, HOLD.
- IDLE:
  - in_ready = 1.
  - Accept when in_valid & in_ready at a rising edge → LOAD.
- LOAD (1 cycle):
  - shift_en = 1, mac_clr = 1, tap_addr = 0, in_ready = 0.
  - Next state: MAC.
- MAC (TAPS cycles):
  - mac_en = 1; tap_addr steps 0, 1, …, TAPS-1, incrementing by 1 per cycle.
  - mac_last = 1 only when tap_addr = TAPS-1.
  - After the cycle with tap_addr = TAPS-1 → HOLD; tap_addr returns to 0.
- HOLD:
  - out_valid = 1; mac_en = 0; the accumulator is frozen.
  - On out_valid & out_ready: frame_cnt increments → IDLE.
  - out_valid stays high for as long as out_ready is low (no timeout).
- Cycle counts:
  - Latency from accept edge to out_valid high = TAPS+1 cycles (1 LOAD + TAPS MAC).
  - With out_ready tied high, the minimum accept-to-accept interval is TAPS+3 cycles (LOAD + TAPS MAC + HOLD + IDLE).
- No input buffering:
  - in_valid arriving while busy is not accepted; upstream must hold the sample until in_ready.
  - The sequencer never drops or reorders an accepted sample.
- shift_en and mac_clr are asserted in the same cycle, exactly once per accepted sample.
- mac_en is never high in the same cycle as mac_clr or out_valid.
- If in_valid and out_ready are both high in HOLD, only the output handshake completes; the input is accepted in the following IDLE cycle.
- tap_addr never exceeds TAPS-1; all codes ≥ TAPS are unreachable.
- busy = 1 in LOAD, MAC and HOLD.

Test Plan:
- Reset, then single sample: rst_n low 5 cycles, in_valid pulsed 1 cycle in IDLE.
  - shift_en and mac_clr high for exactly 1 cycle; mac_en high for exactly 64 cycles.
  - tap_addr sequence 0..63; mac_last high only at 63; out_valid rises 65 cycles after the accept edge.
- Back-to-back streaming: in_valid and out_ready held high for 10 samples.
  - Accept edges exactly 67 cycles apart; frame_cnt = 10 at the end; in_ready low throughout each frame.
- Backpressure: out_ready low for 20 cycles in HOLD.
  - out_valid held 20 cycles; tap_addr = 0 and mac_en = 0 throughout; in_ready stays 0.
  - Release out_ready → IDLE the next cycle.
- Mid-frame reset: assert rst_n low when tap_addr = 30.
  - All outputs at reset values immediately (asynchronous); no out_valid afterwards.
  - The next accepted sample starts at tap_addr 0.
- Input held while busy: in_valid high continuously from tap_addr = 10 of frame N.
  - No second shift_en during frame N; the sample is accepted in the first IDLE cycle after the HOLD handshake.
- Counter wrap: preload/force frame_cnt = 0xFFFF, complete one frame → frame_cnt = 0x0000.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fir_mac_sequencer
// Description : Control sequencer for a time-multiplexed FIR datapath that
//               has one delay line, one coefficient ROM and one MAC unit.
//               A valid/ready handshake accepts one sample per frame. The
//               sequencer then issues one LOAD cycle (shift + clear) and TAPS
//               MAC cycles, and holds the result until downstream accepts it.
//
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous assert, active-low reset
//               in_valid   - upstream sample available
//               in_ready   - sequencer idle, can take a sample
//               out_ready  - downstream accepts the result
//               out_valid  - accumulator holds a complete result
//               shift_en   - one-cycle strobe that shifts the sample in
//               tap_addr   - shared delay-line / coefficient ROM index
//               mac_clr    - clear the accumulator
//               mac_en     - accumulate data x coeff this cycle
//               mac_last   - final accumulate cycle (tap_addr == TAPS-1)
//               busy       - high in every state except IDLE
//               frame_cnt  - completed output handshakes, wraps at 16 bits
//
// Revision    : 1.0 - initial release
// ============================================================================
module fir_mac_sequencer #(
    parameter int TAPS          = 64,
    parameter int COUNT_BIT_NUM = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic                     shift_en,
    output logic [COUNT_BIT_NUM-1:0] tap_addr,
    output logic                     mac_clr,
    output logic                     mac_en,
    output logic                     mac_last,
    output logic                     busy,
    output logic [15:0]              frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MAC  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [COUNT_BIT_NUM-1:0] c_LAST_TAP = COUNT_BIT_NUM'(TAPS - 1);
    localparam logic [COUNT_BIT_NUM-1:0] c_TAP_ONE  = COUNT_BIT_NUM'(1);

    state_t                   r_state;
    logic [COUNT_BIT_NUM-1:0] r_tap_addr;
    logic [15:0]              r_frame_cnt;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_shift_en;
    logic                     r_mac_clr;
    logic                     r_mac_en;
    logic                     r_mac_last;
    logic                     r_busy;

    logic [COUNT_BIT_NUM-1:0] w_tap_next;

    assign w_tap_next = r_tap_addr + c_TAP_ONE;

    // Every output flop is loaded with the value that belongs to the state
    // being entered, so the outputs change in the same cycle as the state
    // and nothing combinational sits between the inputs and the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tap_addr  <= '0;
            r_frame_cnt <= 16'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_shift_en  <= 1'b0;
            r_mac_clr   <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_shift_en <= 1'b1;
                        r_mac_clr  <= 1'b1;
                        r_tap_addr <= '0;
                    end
                end

                S_LOAD: begin
                    r_state    <= S_MAC;
                    r_shift_en <= 1'b0;
                    r_mac_clr  <= 1'b0;
                    r_mac_en   <= 1'b1;
                    r_tap_addr <= '0;
                    // TAPS >= 2, so tap 0 is never the final tap.
                    r_mac_last <= 1'b0;
                end

                S_MAC: begin
                    if (r_tap_addr == c_LAST_TAP) begin
                        r_state     <= S_HOLD;
                        r_mac_en    <= 1'b0;
                        r_mac_last  <= 1'b0;
                        r_tap_addr  <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_tap_addr <= w_tap_next;
                        // Look one tap ahead so mac_last lines up with the
                        // registered tap_addr of the final accumulate.
                        r_mac_last <= (w_tap_next == c_LAST_TAP);
                    end
                end

                S_HOLD: begin
                    // A pending input is deliberately ignored here; it is
                    // picked up in the IDLE cycle that follows.
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_tap_addr  <= '0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_shift_en  <= 1'b0;
                    r_mac_clr   <= 1'b0;
                    r_mac_en    <= 1'b0;
                    r_mac_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign shift_en  = r_shift_en;
    assign tap_addr  = r_tap_addr;
    assign mac_clr   = r_mac_clr;
    assign mac_en    = r_mac_en;
    assign mac_last  = r_mac_last;
    assign busy      = r_busy;
    assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_mac_sequencer
// Description : Self-checking bench for fir_mac_sequencer. Stimulus pushes
//               the expected frame count for each accepted sample into a
//               queue; a monitor checks frame protocol and pops the queue on
//               every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_mac_sequencer;

    localparam int TAPS = 64;
    localparam int CB   = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          out_ready;
    logic          in_ready;
    logic          out_valid;
    logic          shift_en;
    logic [CB-1:0] tap_addr;
    logic          mac_clr;
    logic          mac_en;
    logic          mac_last;
    logic          busy;
    logic [15:0]   frame_cnt;

    fir_mac_sequencer #(
        .TAPS          (TAPS),
        .COUNT_BIT_NUM (CB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .shift_en  (shift_en),
        .tap_addr  (tap_addr),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .mac_last  (mac_last),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_cnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: per-frame protocol statistics and scoreboard pop
    // ------------------------------------------------------------------
    bit   m_in_frame = 0;
    bit   m_hs       = 0;
    int   m_acc, m_sh, m_clr, m_en, m_last, m_exp_tap;
    bit   m_bad_tap, m_bad_last, m_overlap, m_ir_bad, m_busy_bad;
    logic [15:0] m_exp;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_in_frame = 0;
            m_hs       = 0;
        end else begin
            if (m_hs) begin
                m_hs = 0;
                chk("scoreboard_has_entry", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    m_exp = exp_q.pop_front();
                    chk("frame_cnt", frame_cnt, m_exp);
                end
                chk("idle_after_handshake", {in_ready, out_valid, busy}, 3'b100);
            end
            if (m_in_frame) begin
                if (out_valid) begin
                    m_in_frame = 0;
                    chk("latency", cyc - m_acc - 1, TAPS + 1);
                    chk("shift_en_count", m_sh, 1);
                    chk("mac_clr_count", m_clr, 1);
                    chk("mac_en_count", m_en, TAPS);
                    chk("tap_sequence_bad", m_bad_tap, 0);
                    chk("mac_last_count", m_last, 1);
                    chk("mac_last_position_bad", m_bad_last, 0);
                    chk("mac_en_overlap", m_overlap, 0);
                    chk("in_ready_in_frame", m_ir_bad, 0);
                    chk("busy_dropped_in_frame", m_busy_bad, 0);
                end else begin
                    if (shift_en) m_sh++;
                    if (mac_clr) begin
                        m_clr++;
                        if (tap_addr != 0) m_bad_tap = 1;
                    end
                    if (mac_en) begin
                        m_en++;
                        if (int'(tap_addr) != m_exp_tap) m_bad_tap = 1;
                        m_exp_tap++;
                    end
                    if (mac_last) begin
                        m_last++;
                        if (int'(tap_addr) != TAPS - 1 || !mac_en) m_bad_last = 1;
                    end
                    if (mac_en && (mac_clr || out_valid)) m_overlap = 1;
                    if (in_ready) m_ir_bad = 1;
                    if (!busy) m_busy_bad = 1;
                end
            end
            if (in_valid && in_ready) begin
                m_in_frame = 1;
                m_acc      = cyc;
                m_sh = 0; m_clr = 0; m_en = 0; m_last = 0; m_exp_tap = 0;
                m_bad_tap = 0; m_bad_last = 0; m_overlap = 0; m_ir_bad = 0; m_busy_bad = 0;
            end
            if (out_valid && out_ready) m_hs = 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready,  1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_shift_en"},  shift_en,  0);
        chk({tag, "_tap_addr"},  tap_addr,  0);
        chk({tag, "_mac_clr"},   mac_clr,   0);
        chk({tag, "_mac_en"},    mac_en,    0);
        chk({tag, "_mac_last"},  mac_last,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_frame_cnt"}, frame_cnt, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        model_cnt = 16'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    // Raise in_valid, wait for the accepting cycle, record the expectation.
    task automatic issue(input bit drop, output int acc);
        bit found = 0;
        acc = 0;
        @(posedge clk); #2;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge clk);
            if (in_ready) begin
                found = 1;
                acc   = cyc;
            end
        end
        chk("accept_within_budget", found, 1);
        if (found) begin
            model_cnt = model_cnt + 16'd1;
            exp_q.push_back(model_cnt);
        end
        if (drop) begin
            @(posedge clk); #2;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_tap(input int v);
        bit found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (mac_en && int'(tap_addr) == v) found = 1;
        end
        chk("reach_tap", found, 1);
    endtask

    task automatic wait_idle();
        bit found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (!busy && !m_hs && exp_q.size() == 0) found = 1;
        end
        chk("drain_within_budget", found, 1);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int acc[10];
    int a1, a2, ov_cnt, hold_ok;
    bit seen;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        model_cnt = 16'd0;

        // Reset, then a single sample pulsed for one cycle
        do_reset();
        issue(1'b1, a1);
        wait_idle();
        chk("single_frame_cnt", frame_cnt, 1);

        // Back-to-back streaming, 10 samples
        do_reset();
        for (int i = 0; i < 10; i++) issue(i == 9, acc[i]);
        for (int i = 1; i < 10; i++) chk("stream_interval", acc[i] - acc[i-1], TAPS + 3);
        wait_idle();
        chk("stream_frame_cnt", frame_cnt, 10);

        // Backpressure: out_ready low for 20 HOLD cycles
        @(posedge clk); #2;
        out_ready = 1'b0;
        issue(1'b1, a1);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk("out_valid_seen", seen, 1);
        hold_ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid && tap_addr == 0 && !mac_en && !in_ready && busy) hold_ok++;
        end
        chk("hold_backpressure", hold_ok, 20);
        @(posedge clk); #2;
        out_ready = 1'b1;
        wait_idle();

        // Mid-frame asynchronous reset at tap 30
        issue(1'b1, a1);
        wait_tap(30);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        exp_q.delete();
        model_cnt = 16'd0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        chk("no_out_valid_after_reset", ov_cnt, 0);
        issue(1'b1, a1);
        wait_idle();
        chk("post_reset_frame_cnt", frame_cnt, 1);

        // Input held high while busy from tap 10
        issue(1'b1, a1);
        wait_tap(10);
        @(posedge clk); #2;
        in_valid = 1'b1;
        issue(1'b1, a2);
        chk("held_input_interval", a2 - a1, TAPS + 3);
        wait_idle();

        // frame_cnt wrap from 0xFFFF
        @(posedge clk); #2;
        force dut.r_frame_cnt = 16'hFFFF;
        @(posedge clk); #2;
        release dut.r_frame_cnt;
        model_cnt = 16'hFFFF;
        issue(1'b1, a1);
        wait_idle();
        chk("wrap_frame_cnt", frame_cnt, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d failures=%0d)", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
